rv_instr_decode: RTL and testbench
==================================

Name: rv_instr_decode

Overview:
Registered RV32I instruction field decoder with a built-in 12-to-32-bit sign-extension stage. It sits between instruction fetch and the execute/control unit. It splits a 32-bit instruction into register indices, opcode/funct fields and format-specific immediates, and provides sign-extended 32-bit versions of the 12-bit immediates. All outputs are registered with one cycle of latency.

Parameters:
None.

Ports:
iwClk  in  1  single clock, rising edge
iwRst  in  1  reset, synchronous, active-high
iwValid  in  1  iwInstr is valid this cycle
iwInstr  in  32  instruction word
orValid  out  1  registered iwValid
orRs1  out  5  instr[19:15]
orRs2  out  5  instr[24:20]
orRd  out  5  instr[11:7]
orOpCode  out  7  instr[6:0]
orFunct3  out  3  instr[14:12]
orFunct7  out  7  instr[31:25]
orImmediate20  out  20  U or J immediate
orImmediate12  out  12  I immediate, instr[31:20]
orImmediate12SClass  out  12  S or B immediate
orImmediate12Ext  out  32  sign-extended orImmediate12
orImmediate12SClassExt  out  32  sign-extended orImmediate12SClass
orKnownOpcode  out  1  opcode is a supported RV32I major opcode

Behaviour:
- Reset: on a rising iwClk edge with iwRst=1, every output register goes to 0. This includes orValid and orKnownOpcode. Reset overrides iwValid.
- Capture: on a rising edge with iwRst=0 and iwValid=1, all outputs update from iwInstr and orValid=1. Latency is exactly 1 cycle.
- Hold: on a rising edge with iwRst=0 and iwValid=0, orValid=0 and all other outputs hold their previous values.
- Register fields and opcode/funct fields are plain bit slices and are always decoded, regardless of format.
- orImmediate20:
  - If opcode = 1101111 (JAL): {instr[31], instr[19:12], instr[20], instr[30:21]}. This is the J offset divided by 2.
  - Otherwise: instr[31:12] (U format).
- orImmediate12 = instr[31:20] for every opcode.
- orImmediate12SClass:
  - If opcode = 1100011 (BRANCH): {instr[31], instr[7], instr[30:25], instr[11:8]}. This is the B offset divided by 2.
  - Otherwise: {instr[31:25], instr[11:7]} (S format).
- Sign extension rule, one shared combinational function used for both 12-bit immediates: out[11:0] = in[11:0] and out[31:12] = in[11] replicated. No zero-extension mode.
- orKnownOpcode = 1 for opcodes 0110111 (LUI), 0010111 (AUIPC), 1101111 (JAL), 1100111 (JALR), 1100011 (BRANCH), 0000011 (LOAD), 0100011 (STORE), 0010011 (OP-IMM), 0110011 (OP). It is 0 for all other opcodes.
- No funct3/funct7 legality checking; that is the execute unit's job.
- All values are computed from the current iwInstr only. No state exists other than the output registers.
- Boundary conditions:
  - Bit 11 = 1 gives a 0xFFFFF upper field.
  - instr = 0x00000000 decodes to all-zero fields with orKnownOpcode=0.
  - instr = 0xFFFFFFFF gives every immediate all ones.

Test Plan:
- Reset: assert iwRst for 2 cycles while iwValid=1 and iwInstr=0xFFFFFFFF -> all outputs 0. Deassert iwRst; on the next edge outputs reflect the instruction.
- addi x1,x2,-1 (0xFFF10093), iwValid=1 -> next cycle:
  - rd=1, rs1=2, opcode=0x13, funct3=0
  - orImmediate12=0xFFF, orImmediate12Ext=0xFFFFFFFF
  - orKnownOpcode=1, orValid=1
- sw x5,8(x2) (0x00512423) -> rs1=2, rs2=5, funct3=2, opcode=0x23, orImmediate12SClass=0x008, orImmediate12SClassExt=0x00000008.
- beq x0,x0,-4 (0xFE000EE3) -> orImmediate12SClass=0xFFE and orImmediate12SClassExt=0xFFFFFFFE. Then lui x3,0xABCDE (0xABCDE1B7) -> rd=3, orImmediate20=0xABCDE.
- jal x1,+8 (0x008000EF) -> rd=1, orImmediate20=0x00004, opcode=0x6F. Then opcode 0x7F word (0x0000007F) -> orKnownOpcode=0.
- Hold and mid-operation reset:
  - Capture 0xFFF10093, then drop iwValid and change iwInstr -> orValid=0 and fields unchanged.
  - Then pulse iwRst for 1 cycle with iwValid=1 -> all outputs 0 on that edge.

Source files
------------

// File: rtl/rv_instr_decode.sv
// rv_instr_decode: registered RV32I field decoder with 12-to-32-bit immediate sign extension
// Ports: iwClk/iwRst clock and sync active-high reset; iwValid/iwInstr incoming instruction;
// orValid registered valid; orRs1/orRs2/orRd/orOpCode/orFunct3/orFunct7 raw field slices;
// orImmediate20 U or J immediate; orImmediate12 I immediate; orImmediate12SClass S or B immediate;
// orImmediate12Ext/orImmediate12SClassExt sign-extended 12-bit immediates; orKnownOpcode RV32I major opcode hit.
module rv_instr_decode (
  input  logic        iwClk,
  input  logic        iwRst,
  input  logic        iwValid,
  input  logic [31:0] iwInstr,
  output logic        orValid,
  output logic [4:0]  orRs1,
  output logic [4:0]  orRs2,
  output logic [4:0]  orRd,
  output logic [6:0]  orOpCode,
  output logic [2:0]  orFunct3,
  output logic [6:0]  orFunct7,
  output logic [19:0] orImmediate20,
  output logic [11:0] orImmediate12,
  output logic [11:0] orImmediate12SClass,
  output logic [31:0] orImmediate12Ext,
  output logic [31:0] orImmediate12SClassExt,
  output logic        orKnownOpcode
);
  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [19:0] imm20;
    logic [11:0] imm12;
    logic [11:0] imm12s;
    logic [31:0] imm12_ext;
    logic [31:0] imm12s_ext;
    logic        known;
  } fields_t;
  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction
  fields_t f_d, f_q, dec;
  logic    valid_d, valid_q;
  always_comb begin
    dec            = '0;
    dec.rs1        = iwInstr[19:15];
    dec.rs2        = iwInstr[24:20];
    dec.rd         = iwInstr[11:7];
    dec.opcode     = iwInstr[6:0];
    dec.funct3     = iwInstr[14:12];
    dec.funct7     = iwInstr[31:25];
    // J and B immediates are stored as offset/2 with their scrambled bit order undone
    dec.imm20      = (dec.opcode == 7'b1101111) ? {iwInstr[31], iwInstr[19:12], iwInstr[20], iwInstr[30:21]}
                                                : iwInstr[31:12];
    dec.imm12      = iwInstr[31:20];
    dec.imm12s     = (dec.opcode == 7'b1100011) ? {iwInstr[31], iwInstr[7], iwInstr[30:25], iwInstr[11:8]}
                                                : {iwInstr[31:25], iwInstr[11:7]};
    dec.imm12_ext  = sext12(dec.imm12);
    dec.imm12s_ext = sext12(dec.imm12s);
    dec.known      = dec.opcode inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                                        7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
    valid_d        = iwValid;
    f_d            = iwValid ? dec : f_q;
  end
  always_ff @(posedge iwClk) begin
    if (iwRst) begin
      valid_q <= 1'b0;
      f_q     <= '0;
    end else begin
      valid_q <= valid_d;
      f_q     <= f_d;
    end
  end
  assign orValid                = valid_q;
  assign orRs1                  = f_q.rs1;
  assign orRs2                  = f_q.rs2;
  assign orRd                   = f_q.rd;
  assign orOpCode               = f_q.opcode;
  assign orFunct3               = f_q.funct3;
  assign orFunct7               = f_q.funct7;
  assign orImmediate20          = f_q.imm20;
  assign orImmediate12          = f_q.imm12;
  assign orImmediate12SClass    = f_q.imm12s;
  assign orImmediate12Ext       = f_q.imm12_ext;
  assign orImmediate12SClassExt = f_q.imm12s_ext;
  assign orKnownOpcode          = f_q.known;
endmodule

// File: tb/tb_rv_instr_decode.sv
// tb_rv_instr_decode: directed self-checking bench for rv_instr_decode
module tb_rv_instr_decode;
  logic        clk = 1'b0;
  logic        rst, valid;
  logic [31:0] instr;
  logic        o_valid, o_known;
  logic [4:0]  o_rs1, o_rs2, o_rd;
  logic [6:0]  o_op, o_f7;
  logic [2:0]  o_f3;
  logic [19:0] o_imm20;
  logic [11:0] o_imm12, o_imm12s;
  logic [31:0] o_imm12_ext, o_imm12s_ext;
  int          n_tests = 0;
  int          n_fail = 0;
  always #5 clk = ~clk;
  rv_instr_decode dut (
    .iwClk(clk), .iwRst(rst), .iwValid(valid), .iwInstr(instr),
    .orValid(o_valid), .orRs1(o_rs1), .orRs2(o_rs2), .orRd(o_rd),
    .orOpCode(o_op), .orFunct3(o_f3), .orFunct7(o_f7),
    .orImmediate20(o_imm20), .orImmediate12(o_imm12), .orImmediate12SClass(o_imm12s),
    .orImmediate12Ext(o_imm12_ext), .orImmediate12SClassExt(o_imm12s_ext),
    .orKnownOpcode(o_known)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic r, input logic v, input logic [31:0] i);
    @(negedge clk);
    rst = r;
    valid = v;
    instr = i;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, ".valid"}, 32'(o_valid), 0);
    chk({tag, ".rs1"}, 32'(o_rs1), 0);
    chk({tag, ".rs2"}, 32'(o_rs2), 0);
    chk({tag, ".rd"}, 32'(o_rd), 0);
    chk({tag, ".op"}, 32'(o_op), 0);
    chk({tag, ".f3"}, 32'(o_f3), 0);
    chk({tag, ".f7"}, 32'(o_f7), 0);
    chk({tag, ".imm20"}, 32'(o_imm20), 0);
    chk({tag, ".imm12"}, 32'(o_imm12), 0);
    chk({tag, ".imm12s"}, 32'(o_imm12s), 0);
    chk({tag, ".imm12ext"}, o_imm12_ext, 0);
    chk({tag, ".imm12sext"}, o_imm12s_ext, 0);
    chk({tag, ".known"}, 32'(o_known), 0);
  endtask
  logic [6:0] ops   [12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h7F};
  logic       known [12] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
  initial begin
    rst = 1'b1;
    valid = 1'b1;
    instr = 32'hFFFF_FFFF;
    step(1, 1, 32'hFFFF_FFFF);
    chk_zero("rst1");
    step(1, 1, 32'hFFFF_FFFF);
    chk_zero("rst2");
    step(0, 1, 32'hFFFF_FFFF);
    chk("ones.valid", 32'(o_valid), 1);
    chk("ones.imm20", 32'(o_imm20), 32'hFFFFF);
    chk("ones.imm12", 32'(o_imm12), 32'hFFF);
    chk("ones.imm12s", 32'(o_imm12s), 32'hFFF);
    chk("ones.imm12ext", o_imm12_ext, 32'hFFFF_FFFF);
    chk("ones.imm12sext", o_imm12s_ext, 32'hFFFF_FFFF);
    chk("ones.known", 32'(o_known), 0);
    step(0, 1, 32'h0000_0000);
    chk("zero.valid", 32'(o_valid), 1);
    chk("zero.imm20", 32'(o_imm20), 0);
    chk("zero.imm12ext", o_imm12_ext, 0);
    chk("zero.rd", 32'(o_rd), 0);
    chk("zero.known", 32'(o_known), 0);
    step(0, 1, 32'hFFF1_0093);
    chk("addi.rd", 32'(o_rd), 1);
    chk("addi.rs1", 32'(o_rs1), 2);
    chk("addi.rs2", 32'(o_rs2), 31);
    chk("addi.op", 32'(o_op), 32'h13);
    chk("addi.f3", 32'(o_f3), 0);
    chk("addi.f7", 32'(o_f7), 32'h7F);
    chk("addi.imm12", 32'(o_imm12), 32'hFFF);
    chk("addi.imm12ext", o_imm12_ext, 32'hFFFF_FFFF);
    chk("addi.imm20", 32'(o_imm20), 32'hFFF10);
    chk("addi.known", 32'(o_known), 1);
    chk("addi.valid", 32'(o_valid), 1);
    step(0, 1, 32'h0051_2423);
    chk("sw.rs1", 32'(o_rs1), 2);
    chk("sw.rs2", 32'(o_rs2), 5);
    chk("sw.rd", 32'(o_rd), 8);
    chk("sw.f3", 32'(o_f3), 2);
    chk("sw.op", 32'(o_op), 32'h23);
    chk("sw.imm12s", 32'(o_imm12s), 32'h008);
    chk("sw.imm12sext", o_imm12s_ext, 32'h0000_0008);
    chk("sw.imm12", 32'(o_imm12), 32'h005);
    step(0, 1, 32'hFE00_0EE3);
    chk("beq.imm12s", 32'(o_imm12s), 32'hFFE);
    chk("beq.imm12sext", o_imm12s_ext, 32'hFFFF_FFFE);
    chk("beq.imm12", 32'(o_imm12), 32'hFE0);
    chk("beq.imm12ext", o_imm12_ext, 32'hFFFF_FFE0);
    step(0, 1, 32'hABCD_E1B7);
    chk("lui.rd", 32'(o_rd), 3);
    chk("lui.imm20", 32'(o_imm20), 32'hABCDE);
    chk("lui.op", 32'(o_op), 32'h37);
    step(0, 1, 32'h0080_00EF);
    chk("jal.rd", 32'(o_rd), 1);
    chk("jal.imm20", 32'(o_imm20), 32'h00004);
    chk("jal.op", 32'(o_op), 32'h6F);
    chk("jal.known", 32'(o_known), 1);
    step(0, 1, 32'h0000_007F);
    chk("op7f.known", 32'(o_known), 0);
    chk("op7f.op", 32'(o_op), 32'h7F);
    for (int i = 0; i < 12; i++) begin
      step(0, 1, {25'h0, ops[i]});
      chk($sformatf("known.%02h", ops[i]), 32'(o_known), 32'(known[i]));
    end
    step(0, 1, 32'hFFF1_0093);
    chk("cap.valid", 32'(o_valid), 1);
    step(0, 0, 32'h0051_2423);
    chk("hold.valid", 32'(o_valid), 0);
    chk("hold.rd", 32'(o_rd), 1);
    chk("hold.rs2", 32'(o_rs2), 31);
    chk("hold.op", 32'(o_op), 32'h13);
    chk("hold.imm12ext", o_imm12_ext, 32'hFFFF_FFFF);
    chk("hold.known", 32'(o_known), 1);
    step(1, 1, 32'hFFF1_0093);
    chk_zero("midrst");
    step(0, 1, 32'hABCD_E1B7);
    chk("post.imm20", 32'(o_imm20), 32'hABCDE);
    chk("post.valid", 32'(o_valid), 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
